// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS constants and FSM state encoding for the framer and sync recovery.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE  = 8'h47;
    localparam int          TS_PKT_LEN    = 188;
    localparam int          TS_HDR_LEN    = 4;
    localparam logic [12:0] TS_NULL_PID   = 13'h1FFF;
    localparam logic [7:0]  TS_STUFF_BYTE = 8'hFF;

    localparam logic [7:0]  TS_HDR_LAST = 8'(TS_HDR_LEN - 1);
    localparam logic [7:0]  TS_PKT_LAST = 8'(TS_PKT_LEN - 1);

    typedef logic [1:0] ts_state_t;

    localparam ts_state_t ST_IDLE    = 2'd0;
    localparam ts_state_t ST_HDR     = 2'd1;
    localparam ts_state_t ST_PAYLOAD = 2'd2;
    localparam ts_state_t ST_NULL    = 2'd3;

endpackage

// File: rtl/ts_packet_framer_if.sv
// Payload-in / TS-byte-out bundle for the packet framer.
interface ts_packet_framer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic       out_ready;
    logic [7:0] byte_out;
    logic       valid;
    logic       sync;

    modport master (
        output in_data, in_valid, in_sop, out_ready,
        input  in_ready, byte_out, valid, sync
    );

    modport slave (
        input  in_data, in_valid, in_sop, out_ready,
        output in_ready, byte_out, valid, sync
    );

endinterface

// File: rtl/ts_header_gen.sv
// Selects the TS header byte for byte position cnt_i; beyond the header it yields stuffing.
module ts_header_gen
    import ts_pkg::*;
(
    input  logic [7:0]  cnt_i,
    input  logic [12:0] pid_i,
    input  logic        pusi_i,
    input  logic [3:0]  cc_i,
    input  logic        null_i,
    output logic [7:0]  byte_o
);

    logic [12:0] pid;
    logic        pusi;
    logic [3:0]  cc;

    // Null packets force PID 0x1FFF, PUSI=0 and CC=0.
    assign pid  = null_i ? TS_NULL_PID : pid_i;
    assign pusi = pusi_i & ~null_i;
    assign cc   = null_i ? 4'd0 : cc_i;

    always_comb begin
        byte_o = TS_STUFF_BYTE;
        unique case (1'b1)
            (cnt_i == 8'd0): byte_o = TS_SYNC_BYTE;
            (cnt_i == 8'd1): byte_o = {1'b0, pusi, 1'b0, pid[12:8]};
            (cnt_i == 8'd2): byte_o = pid[7:0];
            (cnt_i == 8'd3): byte_o = {2'b00, 2'b01, cc};
            default:         byte_o = TS_STUFF_BYTE;
        endcase
    end

endmodule

// File: rtl/ts_packet_framer.sv
// Packs a payload byte stream into 188-byte TS packets with a single PID.
// Define TS_NULL_STUFF_EN to emit null packets whenever no payload is pending at packet start.
module ts_packet_framer
    import ts_pkg::*;
#(
    parameter logic [12:0] PID = 13'h0100
)
(
    input  logic               clk,
    input  logic               rst,
    ts_packet_framer_if.slave  bus
);

    ts_state_t  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cc_q, cc_d;
    logic       pusi_q, pusi_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       sync_q, sync_d;
    logic [7:0] hdr_byte;
    logic       is_null;

`ifdef TS_NULL_STUFF_EN
    assign is_null = (state_q == ST_NULL);
`else
    assign is_null = 1'b0;
`endif

    ts_header_gen u_hdr (
        .cnt_i  (cnt_q),
        .pid_i  (PID),
        .pusi_i (pusi_q),
        .cc_i   (cc_q),
        .null_i (is_null),
        .byte_o (hdr_byte)
    );

    assign bus.in_ready = bus.out_ready && (state_q == ST_PAYLOAD);
    assign bus.byte_out = byte_q;
    assign bus.valid    = valid_q;
    assign bus.sync     = sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cc_d    = cc_q;
        pusi_d  = pusi_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        sync_d  = sync_q;
        if (bus.out_ready) begin
            unique case (1'b1)
                (state_q == ST_IDLE): begin
                    valid_d = 1'b0;
                    sync_d  = 1'b0;
                    // The head payload byte is only peeked here; it is consumed in PAYLOAD.
                    if (bus.in_valid) begin
                        pusi_d  = bus.in_sop;
                        byte_d  = TS_SYNC_BYTE;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                        state_d = ST_HDR;
                        cnt_d   = 8'd1;
                    end
`ifdef TS_NULL_STUFF_EN
                    else begin
                        byte_d  = TS_SYNC_BYTE;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                        state_d = ST_NULL;
                        cnt_d   = 8'd1;
                    end
`endif
                end
                (state_q == ST_HDR): begin
                    byte_d  = hdr_byte;
                    valid_d = 1'b1;
                    sync_d  = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == TS_HDR_LAST) state_d = ST_PAYLOAD;
                end
                (state_q == ST_PAYLOAD): begin
                    sync_d  = 1'b0;
                    valid_d = bus.in_valid;
                    if (bus.in_valid) begin
                        byte_d = bus.in_data;
                        if (cnt_q == TS_PKT_LAST) begin
                            cnt_d   = 8'd0;
                            cc_d    = cc_q + 4'd1;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
`ifdef TS_NULL_STUFF_EN
                (state_q == ST_NULL): begin
                    byte_d  = hdr_byte;
                    valid_d = 1'b1;
                    sync_d  = 1'b0;
                    if (cnt_q == TS_PKT_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    valid_d = 1'b0;
                    sync_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cc_q    <= 4'd0;
            pusi_q  <= 1'b0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cc_q    <= cc_d;
            pusi_q  <= pusi_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: doc/ts_packet_framer.md
Name: ts_packet_framer

Overview:
Transmit-side counterpart of the sync recovery path. It takes a raw elementary payload byte stream and emits a 188-byte MPEG-2 TS packet stream. Each packet carries a 4-byte header (0x47 sync, single configured PID, PUSI, continuity counter) followed by 184 payload bytes. It feeds the mux/output stage and produces the byte/valid/sync format the sync recovery block consumes.

Parameters:
PID, 13'h0100, PID stamped on data packets; 13'h1FFF is illegal (reserved for null).
PKT_LEN is not a parameter; it is fixed at 188 from the package.

Ports:
clk  in  1  clock, single domain
rst  in  1  synchronous reset, active-high
in_data  in  8  payload byte
in_valid  in  1  in_data valid
in_sop  in  1  payload byte is the first byte of a PES unit; sampled only at packet start
in_ready  out  1  payload byte accepted when in_valid && in_ready
out_ready  in  1  downstream accepts a byte this cycle
byte_out  out  8  TS byte (registered)
valid  out  1  byte_out valid (registered)
sync  out  1  high with the 0x47 byte of every packet (registered)

Behaviour:
- Reset (rst=1 at posedge): byte_out=0, valid=0, sync=0, state=IDLE, byte counter=0, CC=0. Applies mid-packet; the partial packet is abandoned.
- Slot rule: outputs update only on a posedge with out_ready=1. With out_ready=0 all outputs and state hold, and in_ready=0.
- in_ready = out_ready && state==PAYLOAD (combinational). Latency: an accepted byte appears on byte_out the next cycle.
- States: IDLE, HDR, PAYLOAD, NULL_PKT (NULL_PKT exists only with the feature enabled).
- IDLE, slot, in_valid=1:
  - Latch pusi=in_sop; do not consume the byte.
  - Emit 0x47 with valid=1 and sync=1.
  - Go to HDR with cnt=1.
- IDLE, slot, in_valid=0: valid=0, sync=0 (see Optional Feature).
- HDR: emit one header byte per slot, cnt 1..3:
  - byte1 = {1'b0, pusi, 1'b0, PID[12:8]}
  - byte2 = PID[7:0]
  - byte3 = {2'b00, 2'b01, CC}
  - After byte3 go to PAYLOAD with cnt=4.
- PAYLOAD, slot, in_valid=1: consume the byte, emit it, cnt++.
- PAYLOAD, slot, in_valid=0: valid=0 and cnt holds. Gaps are allowed; the packet always completes at 188 valid bytes.
- End of data packet: after the byte with cnt=187 is emitted, CC = CC+1 mod 16 and the next state is IDLE.
  - A new packet may start on the very next slot, giving zero gap between packets.
- sync=1 only on header byte 0 and 0 otherwise. in_sop is ignored on any byte that does not begin a packet.
- cnt is 8-bit and never exceeds 187. CC is 4-bit and wraps 15->0.

Optional Feature:
Macro TS_NULL_STUFF_EN.
- Defined: in IDLE, a slot with in_valid=0 starts a null packet.
  - Bytes: 47 1F FF 10, then 184 x 0xFF; sync on 0x47.
  - The null packet runs to completion with in_ready=0, even if in_valid rises.
  - CC is not affected.
  - Output is continuous (valid=1 every slot).
- Undefined: no null packets. The output idles with valid=0, and the NULL_PKT state and its logic are absent.

Decomposition:
- Package ts_pkg holds:
  - TS_SYNC_BYTE=8'h47, TS_PKT_LEN=188, TS_HDR_LEN=4, TS_NULL_PID=13'h1FFF, TS_STUFF_BYTE=8'hFF
  - State enum typedef, shared with sync recovery where applicable.
- Optional sub-module ts_header_gen: combinational mux (cnt, pid, pusi, cc, null) -> header byte. Everything else stays in the top FSM.

Test Plan:
1. Reset, then 184 bytes 0x00..0xB7 continuous with in_sop on the first, out_ready=1 -> bytes 47 41 00 10 00..B7; valid on 188 consecutive cycles; sync only on the 0x47 byte.
2. 17 back-to-back packets, no in_sop -> byte3 runs 10,11..1F, then 10 on packet 17; byte1=01; no idle gap between packets.
3. out_ready low for 5 cycles at payload byte 50 -> byte_out/valid/sync held, in_ready=0, no byte lost or duplicated, total 188.
4. in_valid low for 3 cycles mid-payload -> 3 valid=0 cycles, cnt holds, packet still 188 valid bytes, CC increments once.
5. TS_NULL_STUFF_EN defined, in_valid=0 in IDLE -> 47 1F FF 10 + 184 FF, with in_valid rising at null byte 20 unconsumed until the next data packet; CC unchanged. Macro undefined -> valid stays 0.
6. rst asserted at payload byte 100 -> next cycle valid=0, sync=0; next packet header 47 xx xx 10 (CC=0).
